// File: rtl/flag_branch_unit.sv
// NZCV flag register with same-cycle forwarding and branch resolution.
// A taken branch raises a one-cycle br_taken pulse and a multi-cycle flush.
module flag_branch_unit #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_zero,
    input  logic       alu_neg,
    input  logic       alu_carry,
    input  logic       alu_ovf,
    input  logic       set_flags,
    input  logic [2:0] br_type,
    input  logic [3:0] cond,
    input  logic       cbz_zero,
    output logic [3:0] flags,
    output logic       br_taken,
    output logic       flush
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

    state_e     state_q, state_d;
    logic [2:0] count_q, count_d;
    logic [3:0] flags_q, flags_d;
    logic       br_q, br_d;
    logic       flush_q, flush_d;

    logic [3:0] alu_flags;
    logic [3:0] eff;
    logic       f_n, f_z, f_c, f_v;
    logic       base;
    logic       cond_true;
    logic       take;

    assign alu_flags = {alu_neg, alu_zero, alu_carry, alu_ovf};

    // Forward a same-cycle flag update into condition evaluation.
    always_comb begin
        eff = set_flags ? alu_flags : flags_q;
        f_n = eff[3];
        f_z = eff[2];
        f_c = eff[1];
        f_v = eff[0];
        base = 1'b1;
        case (cond[3:1])
            3'd0:    base = f_z;
            3'd1:    base = f_c;
            3'd2:    base = f_n;
            3'd3:    base = f_v;
            3'd4:    base = f_c & ~f_z;
            3'd5:    base = (f_n == f_v);
            3'd6:    base = ~f_z & (f_n == f_v);
            default: base = 1'b1;
        endcase
        // Odd codes are the complement of their even partner, except AL/NV.
        cond_true = (cond[3:1] == 3'd7) ? 1'b1 : (base ^ cond[0]);
    end

    always_comb begin
        take = 1'b0;
        case (br_type)
            3'b001:  take = 1'b1;
            3'b010:  take = cbz_zero;
            3'b011:  take = ~cbz_zero;
            3'b100:  take = cond_true;
            default: take = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= 3'd0;
            flags_q <= 4'b0000;
            br_q    <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            flags_q <= flags_d;
            br_q    <= br_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = FLUSH;
                    count_d = CNT_INIT;
                end
            end
            FLUSH: begin
                if (count_q == 3'd0) begin
                    state_d = IDLE;
                end else begin
                    count_d = count_q - 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = 3'd0;
            end
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        br_d    = 1'b0;
        flush_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (set_flags) begin
                    flags_d = alu_flags;
                end
                br_d    = take;
                flush_d = take;
            end
            FLUSH: begin
                flush_d = (count_q != 3'd0);
            end
            default: begin
                flush_d = 1'b0;
            end
        endcase
    end

    assign flags    = flags_q;
    assign br_taken = br_q;
    assign flush    = flush_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Scoreboard bench for flag_branch_unit: a cycle model pushes expected
// outputs per edge, each test task pops and compares after the edge.
module tb_flag_branch_unit;

    localparam int FC = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       alu_zero = 1'b0;
    logic       alu_neg = 1'b0;
    logic       alu_carry = 1'b0;
    logic       alu_ovf = 1'b0;
    logic       set_flags = 1'b0;
    logic [2:0] br_type = 3'b000;
    logic [3:0] cond = 4'b0000;
    logic       cbz_zero = 1'b0;
    logic [3:0] flags;
    logic       br_taken;
    logic       flush;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] flags;
        logic       bt;
        logic       fl;
    } exp_t;

    exp_t q[$];

    logic [3:0] m_flags = 4'b0000;
    logic       m_state = 1'b0;
    int         m_cnt = 0;
    logic       m_bt = 1'b0;
    logic       m_fl = 1'b0;

    flag_branch_unit #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk),
        .reset(reset),
        .alu_zero(alu_zero),
        .alu_neg(alu_neg),
        .alu_carry(alu_carry),
        .alu_ovf(alu_ovf),
        .set_flags(set_flags),
        .br_type(br_type),
        .cond(cond),
        .cbz_zero(cbz_zero),
        .flags(flags),
        .br_taken(br_taken),
        .flush(flush)
    );

    always #5 clk = ~clk;

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        m_flags = 4'b0000;
        m_state = 1'b0;
        m_cnt = 0;
        m_bt = 1'b0;
        m_fl = 1'b0;
        q.delete();
    endtask

    task automatic tick();
        logic [3:0] a;
        logic [3:0] eff;
        logic take;
        exp_t e;
        a = {alu_neg, alu_zero, alu_carry, alu_ovf};
        if (!m_state) begin
            eff = set_flags ? a : m_flags;
            take = (br_type == 3'b001)
                || (br_type == 3'b010 && cbz_zero)
                || (br_type == 3'b011 && !cbz_zero)
                || (br_type == 3'b100 && cond_ok(cond, eff));
            if (set_flags) m_flags = a;
            m_bt = take;
            m_fl = take;
            if (take) begin
                m_state = 1'b1;
                m_cnt = FC - 1;
            end
        end else begin
            m_bt = 1'b0;
            if (m_cnt == 0) begin
                m_fl = 1'b0;
                m_state = 1'b0;
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
        e.flags = m_flags;
        e.bt = m_bt;
        e.fl = m_fl;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sf, input logic [3:0] nzcv,
                         input logic [2:0] bt, input logic [3:0] c,
                         input logic cz);
        set_flags = sf;
        {alu_neg, alu_zero, alu_carry, alu_ovf} = nzcv;
        br_type = bt;
        cond = c;
        cbz_zero = cz;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 4'b0000, 3'b000, 4'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({flags, br_taken, flush} !== 6'b0) begin
            errors++;
            $display("FAIL reset: got %b/%b/%b want 0000/0/0",
                     flags, br_taken, flush);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_set_flags();
        exp_t e;
        drive(1'b1, 4'b0110, 3'b000, 4'h0, 1'b0);
        tick();
        e = q.pop_front();
        checks++;
        if ({flags, br_taken, flush} !== {e.flags, e.bt, e.fl}) begin
            errors++;
            $display("FAIL set_flags_sb: got %b/%b/%b want %b/%b/%b",
                     flags, br_taken, flush, e.flags, e.bt, e.fl);
        end
        checks++;
        if (flags !== 4'b0110) begin
            errors++;
            $display("FAIL set_flags: got %b want 0110", flags);
        end
    endtask

    task automatic test_forward();
        exp_t e;
        drive(1'b1, 4'b0000, 3'b000, 4'h0, 1'b0);
        tick();
        void'(q.pop_front());
        drive(1'b1, 4'b0100, 3'b100, 4'h0, 1'b0);
        tick();
        e = q.pop_front();
        checks++;
        if ({flags, br_taken, flush} !== {e.flags, e.bt, e.fl}) begin
            errors++;
            $display("FAIL forward_sb: got %b/%b/%b want %b/%b/%b",
                     flags, br_taken, flush, e.flags, e.bt, e.fl);
        end
        checks++;
        if (br_taken !== 1'b1) begin
            errors++;
            $display("FAIL forward_eq: br_taken got %b want 1", br_taken);
        end
        drive(1'b0, 4'b0000, 3'b000, 4'h0, 1'b0);
        repeat (3) begin
            tick();
            e = q.pop_front();
            checks++;
            if ({flags, br_taken, flush} !== {e.flags, e.bt, e.fl}) begin
                errors++;
                $display("FAIL forward_tail: got %b/%b/%b want %b/%b/%b",
                         flags, br_taken, flush, e.flags, e.bt, e.fl);
            end
        end
    endtask

    task automatic test_cbz();
        exp_t e;
        int pulses = 0;
        int fcyc = 0;
        drive(1'b0, 4'b0000, 3'b010, 4'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) drive(1'b0, 4'b0000, 3'b000, 4'h0, 1'b0);
            e = q.pop_front();
            pulses += int'(br_taken);
            fcyc += int'(flush);
            checks++;
            if ({flags, br_taken, flush} !== {e.flags, e.bt, e.fl}) begin
                errors++;
                $display("FAIL cbz_sb%0d: got %b/%b/%b want %b/%b/%b", i,
                         flags, br_taken, flush, e.flags, e.bt, e.fl);
            end
        end
        checks++;
        if (pulses != 1 || fcyc != FC) begin
            errors++;
            $display("FAIL cbz_len: pulses %0d flush %0d want 1 %0d",
                     pulses, fcyc, FC);
        end
        drive(1'b0, 4'b0000, 3'b011, 4'h0, 1'b1);
        tick();
        e = q.pop_front();
        checks++;
        if (br_taken !== 1'b0 || flush !== 1'b0 || e.bt !== 1'b0) begin
            errors++;
            $display("FAIL cbnz_nt: got %b/%b want 0/0", br_taken, flush);
        end
    endtask

    task automatic test_flush_ignore();
        exp_t e;
        logic [3:0] f0;
        f0 = flags;
        drive(1'b0, 4'b0000, 3'b001, 4'h0, 1'b0);
        tick();
        void'(q.pop_front());
        drive(1'b1, 4'b1011, 3'b001, 4'h0, 1'b0);
        for (int i = 0; i < FC; i++) begin
            tick();
            e = q.pop_front();
            checks++;
            if ({flags, br_taken, flush} !== {e.flags, e.bt, e.fl}
                || br_taken !== 1'b0 || flags !== f0) begin
                errors++;
                $display("FAIL flush_ign%0d: got %b/%b/%b want %b/0/%b", i,
                         flags, br_taken, flush, f0, e.fl);
            end
        end
        drive(1'b0, 4'b0000, 3'b001, 4'h0, 1'b0);
        tick();
        e = q.pop_front();
        checks++;
        if (br_taken !== 1'b1 || e.bt !== 1'b1) begin
            errors++;
            $display("FAIL after_flush: br_taken got %b want 1", br_taken);
        end
        drive(1'b0, 4'b0000, 3'b000, 4'h0, 1'b0);
        repeat (FC) begin
            tick();
            void'(q.pop_front());
        end
    endtask

    task automatic test_invalid();
        exp_t e;
        for (int t = 5; t < 8; t++) begin
            drive(1'b0, 4'b0000, 3'(t), 4'hE, 1'b1);
            tick();
            e = q.pop_front();
            checks++;
            if ({br_taken, flush} !== 2'b00 || {e.bt, e.fl} !== 2'b00) begin
                errors++;
                $display("FAIL invalid%0d: got %b/%b want 0/0",
                         t, br_taken, flush);
            end
        end
    endtask

    task automatic test_sweep();
        exp_t e;
        logic [15:0] want;
        want = 16'hD65A;
        drive(1'b1, 4'b1001, 3'b000, 4'h0, 1'b0);
        tick();
        void'(q.pop_front());
        for (int c = 0; c < 16; c++) begin
            drive(1'b0, 4'b0000, 3'b100, 4'(c), 1'b0);
            tick();
            e = q.pop_front();
            checks++;
            if (br_taken !== want[c] || br_taken !== e.bt
                || flush !== e.fl) begin
                errors++;
                $display("FAIL sweep_c%0d: got %b/%b want %b/%b",
                         c, br_taken, flush, want[c], e.fl);
            end
            drive(1'b0, 4'b0000, 3'b000, 4'h0, 1'b0);
            repeat (FC) begin
                tick();
                e = q.pop_front();
                checks++;
                if ({flags, br_taken, flush} !== {e.flags, e.bt, e.fl}) begin
                    errors++;
                    $display("FAIL sweep_gap%0d: got %b/%b/%b want %b/%b/%b",
                             c, flags, br_taken, flush, e.flags, e.bt, e.fl);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        drive(1'b0, 4'b0000, 3'b001, 4'h0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            tick();
            e = q.pop_front();
            checks++;
            if ({flags, br_taken, flush} !== {e.flags, e.bt, e.fl}) begin
                errors++;
                $display("FAIL b2b%0d: got %b/%b/%b want %b/%b/%b", i,
                         flags, br_taken, flush, e.flags, e.bt, e.fl);
            end
        end
        drive(1'b0, 4'b0000, 3'b000, 4'h0, 1'b0);
        repeat (FC) begin
            tick();
            void'(q.pop_front());
        end
    endtask

    task automatic test_reset_midflush();
        drive(1'b1, 4'b1111, 3'b000, 4'h0, 1'b0);
        tick();
        void'(q.pop_front());
        drive(1'b0, 4'b0000, 3'b001, 4'h0, 1'b0);
        tick();
        void'(q.pop_front());
        drive(1'b0, 4'b0000, 3'b000, 4'h0, 1'b0);
        checks++;
        if (flush !== 1'b1 || flags !== 4'b1111) begin
            errors++;
            $display("FAIL pre_reset: flush %b flags %b want 1 1111",
                     flush, flags);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({flags, br_taken, flush} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset: got %b/%b/%b want 0000/0/0",
                     flags, br_taken, flush);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        tick();
        void'(q.pop_front());
        checks++;
        if ({flags, br_taken, flush} !== 6'b0) begin
            errors++;
            $display("FAIL post_reset: got %b/%b/%b want 0000/0/0",
                     flags, br_taken, flush);
        end
    endtask

    initial begin
        test_reset();
        test_set_flags();
        test_forward();
        test_cbz();
        test_flush_ignore();
        test_invalid();
        test_sweep();
        test_back_to_back();
        test_reset_midflush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
